peripheral_bus_master: RTL and testbench
========================================

PERIPHERAL_BUS_MASTER -- requirements
Module: peripheral_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1024, busy cycles tolerated before abort; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 req_valid  input  1  requester has a transaction.
REQ-005 req_ready  output  1  block accepts a transaction this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_address  input  24  target peripheral bus address.
REQ-008 req_byteSelect  input  4  byte lane enables.
REQ-009 req_dataWrite  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion strobe.
REQ-011 rsp_dataRead  output  32  read data; ~0 on error.
REQ-012 rsp_error  output  1  no device responded, or timeout.
REQ-013 peripheralBus_we  output  1  write strobe.
REQ-014 peripheralBus_oe  output  1  read strobe.
REQ-015 peripheralBus_address  output  24  address.
REQ-016 peripheralBus_byteSelect  output  4  byte lanes.
REQ-017 peripheralBus_dataWrite  output  32  write data.
REQ-018 peripheralBus_busy  input  1  responder stall; may be combinational on address/strobes.
REQ-019 peripheralBus_dataRead  input  32  responder read data.
REQ-020 requestOutput  input  1  a device decoded the read and drives dataRead.

Function
REQ-021 FSM states: IDLE, ACCESS, RESPOND; all bus outputs registered.
REQ-022 IDLE: req_ready=1; on req_valid, latch write/address/byteSelect/dataWrite, clear timeout counter, go ACCESS next cycle.
REQ-023 req_ready=0 in ACCESS and RESPOND; req_valid there is ignored, no queueing.
REQ-024 ACCESS: peripheralBus_we=req_write, peripheralBus_oe=~req_write; address/byteSelect/dataWrite = latched values, stable throughout ACCESS.
REQ-025 ACCESS, busy=0 at rising edge: transaction completes; read latches peripheralBus_dataRead; go RESPOND.
REQ-026 Read completion with requestOutput=0: rsp_dataRead=32'hFFFFFFFF, rsp_error=1.
REQ-027 Write completion: rsp_dataRead=0, rsp_error=0; requestOutput ignored.
REQ-028 ACCESS, busy=1: increment 16-bit counter; when counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0), abort to RESPOND with rsp_error=1, rsp_dataRead=32'hFFFFFFFF.
REQ-029 Busy low on the same edge the counter would hit TIMEOUT_CYCLES: normal completion wins.
REQ-030 RESPOND: rsp_valid=1 exactly one cycle, we=oe=0, next state IDLE; no back-pressure on response.
REQ-031 Latency: accept at edge N, ACCESS cycle N+1, rsp_valid high cycle N+2 when busy=0; each busy cycle adds one.
REQ-032 we and oe never both 1; both 0 outside ACCESS.
REQ-033 Outside ACCESS, address/byteSelect/dataWrite hold last driven values.
REQ-034 rsp_dataRead/rsp_error hold until next RESPOND.

Reset
REQ-035 rst=0 asynchronously forces IDLE; we, oe, rsp_valid, rsp_error = 0; address, byteSelect, dataWrite, rsp_dataRead, counter = 0; req_ready=0 while rst=0, 1 first cycle after release.
REQ-036 Reset during ACCESS drops we/oe immediately; no rsp_valid for the aborted transaction.

Verification
REQ-037 Write 0x000104, byteSelect 4'hF, data 0xDEADBEEF, busy=0 -> we=1 one cycle, address 0x000104, rsp_valid two cycles after accept, rsp_error=0.
REQ-038 Read 0x000200, busy=0, requestOutput=1, dataRead=0x12345678 -> oe=1 one cycle, rsp_dataRead=0x12345678, rsp_error=0.
REQ-039 Read, requestOutput=0 -> rsp_dataRead=0xFFFFFFFF, rsp_error=1.
REQ-040 Write, busy=1 for 3 cycles -> we held 4 cycles, stable address/data, rsp_valid 5 cycles after accept, req_ready=0 throughout.
REQ-041 TIMEOUT_CYCLES=8, busy stuck 1 -> abort after 8 ACCESS cycles, rsp_error=1, rsp_dataRead=0xFFFFFFFF, we/oe low next cycle.
REQ-042 rst=0 asserted mid-ACCESS -> we/oe 0 same cycle, no rsp_valid, req_ready=1 first cycle after release.

Source files
------------

// File: rtl/peripheral_bus_master.sv
// rtl/peripheral_bus_master.sv - single-outstanding request to peripheral bus master with busy timeout
module peripheral_bus_master #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_address,
  input  logic [3:0]  req_byteSelect,
  input  logic [31:0] req_dataWrite,

  output logic        rsp_valid,
  output logic [31:0] rsp_dataRead,
  output logic        rsp_error,

  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  output logic [23:0] peripheralBus_address,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic        peripheralBus_busy,
  input  logic [31:0] peripheralBus_dataRead,
  input  logic        requestOutput
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND
  } state_t;

  state_t      state;
  logic        write_q;
  logic [15:0] busy_count;
  logic [15:0] busy_count_next;
  logic        timeout_hit;

  // The counter value this busy cycle would leave behind; abort when it lands on the limit.
  assign busy_count_next = busy_count + 16'd1;
  assign timeout_hit     = (TIMEOUT_CYCLES != 16'd0) && (busy_count_next == TIMEOUT_CYCLES);

  // Ready only in IDLE and never while reset is held, so it rises as soon as reset lifts.
  assign req_ready = (state == S_IDLE) && rst;

  // Transaction sequencer: accept, drive the bus until the responder stops stalling, report once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= S_IDLE;
      write_q                  <= 1'b0;
      busy_count               <= 16'd0;
      rsp_valid                <= 1'b0;
      rsp_dataRead             <= 32'd0;
      rsp_error                <= 1'b0;
      peripheralBus_we         <= 1'b0;
      peripheralBus_oe         <= 1'b0;
      peripheralBus_address    <= 24'd0;
      peripheralBus_byteSelect <= 4'd0;
      peripheralBus_dataWrite  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q                  <= req_write;
            peripheralBus_we         <= req_write;
            peripheralBus_oe         <= ~req_write;
            peripheralBus_address    <= req_address;
            peripheralBus_byteSelect <= req_byteSelect;
            peripheralBus_dataWrite  <= req_dataWrite;
            busy_count               <= 16'd0;
            state                    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!peripheralBus_busy) begin
            // Completion takes priority over a timeout landing on the same edge.
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            rsp_valid        <= 1'b1;
            state            <= S_RESPOND;
            if (write_q) begin
              rsp_dataRead <= 32'd0;
              rsp_error    <= 1'b0;
            end else if (requestOutput) begin
              rsp_dataRead <= peripheralBus_dataRead;
              rsp_error    <= 1'b0;
            end else begin
              rsp_dataRead <= 32'hFFFF_FFFF;
              rsp_error    <= 1'b1;
            end
          end else if (timeout_hit) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_dataRead     <= 32'hFFFF_FFFF;
            rsp_error        <= 1'b1;
            busy_count       <= busy_count_next;
            state            <= S_RESPOND;
          end else begin
            busy_count <= busy_count_next;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state            <= S_IDLE;
          peripheralBus_we <= 1'b0;
          peripheralBus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_master.sv
// tb/tb_peripheral_bus_master.sv - randomized scoreboard bench for peripheral_bus_master
module tb_peripheral_bus_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_address;
  logic [3:0]  req_byteSelect;
  logic [31:0] req_dataWrite;
  logic        rsp_valid;
  logic [31:0] rsp_dataRead;
  logic        rsp_error;
  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic [23:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite;
  logic        peripheralBus_busy;
  logic [31:0] peripheralBus_dataRead;
  logic        requestOutput;

  peripheral_bus_master #(.TIMEOUT_CYCLES(16'(T))) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_write                (req_write),
    .req_address              (req_address),
    .req_byteSelect           (req_byteSelect),
    .req_dataWrite            (req_dataWrite),
    .rsp_valid                (rsp_valid),
    .rsp_dataRead             (rsp_dataRead),
    .rsp_error                (rsp_error),
    .peripheralBus_we         (peripheralBus_we),
    .peripheralBus_oe         (peripheralBus_oe),
    .peripheralBus_address    (peripheralBus_address),
    .peripheralBus_byteSelect (peripheralBus_byteSelect),
    .peripheralBus_dataWrite  (peripheralBus_dataWrite),
    .peripheralBus_busy       (peripheralBus_busy),
    .peripheralBus_dataRead   (peripheralBus_dataRead),
    .requestOutput            (requestOutput)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        write;
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          access;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference outcome from the transaction rules: the responder stalls nb cycles, the master gives up after T stalled cycles.
  function automatic exp_t model(input logic w, input logic [23:0] a, input logic [3:0] be,
                                 input logic [31:0] wd, input int nb, input logic ro, input logic [31:0] rd);
    exp_t e;
    e.write = w; e.addr = a; e.be = be; e.wd = wd;
    if (nb >= T) begin
      e.access = T;            e.rd = 32'hFFFF_FFFF; e.err = 1'b1;
    end else begin
      e.access = nb + 1;
      if (w)       begin e.rd = 32'd0;         e.err = 1'b0; end
      else if (ro) begin e.rd = rd;            e.err = 1'b0; end
      else         begin e.rd = 32'hFFFF_FFFF; e.err = 1'b1; end
    end
    e.lat = e.access + 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: checks bus activity against the outstanding transaction and pops it on the response strobe.
  exp_t        mon_e;
  int          acc_cnt = 0;
  logic [31:0] last_rd;
  logic        last_err;
  logic [23:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  always @(negedge clk) begin
    if (!rst) begin
      acc_cnt = 0; last_rd = 0; last_err = 0; last_addr = 0; last_be = 0; last_wd = 0;
    end else begin
      if (peripheralBus_we || peripheralBus_oe) begin
        if (sb.size() == 0) check("unexpected_access", 64'(1), 64'(0));
        else check("bus_drive",
                   {2'b0, peripheralBus_we, peripheralBus_oe, peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite},
                   {2'b0, sb[0].write, ~sb[0].write, sb[0].addr, sb[0].be, sb[0].wd});
        acc_cnt++;
      end else begin
        check("bus_hold", {4'b0, peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite},
              {4'b0, last_addr, last_be, last_wd});
      end
      last_addr = peripheralBus_address; last_be = peripheralBus_byteSelect; last_wd = peripheralBus_dataWrite;
      if (rsp_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 64'(1), 64'(0));
        else begin
          mon_e = sb.pop_front();
          check("rsp_data", {31'b0, rsp_error, rsp_dataRead}, {31'b0, mon_e.err, mon_e.rd});
          check("rsp_latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          check("access_cycles", 64'(acc_cnt), 64'(mon_e.access));
        end
        acc_cnt = 0;
        last_rd = rsp_dataRead; last_err = rsp_error;
      end else begin
        check("rsp_hold", {31'b0, rsp_error, rsp_dataRead}, {31'b0, last_err, last_rd});
      end
    end
  end

  task automatic junk_request();
    req_valid      = 1'($urandom);
    req_write      = 1'($urandom);
    req_address    = 24'($urandom);
    req_byteSelect = 4'($urandom);
    req_dataWrite  = $urandom;
  endtask

  task automatic run_txn(input logic w, input logic [23:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input int nb, input logic ro, input logic [31:0] rd, input int reset_at);
    exp_t e;
    bit   done;
    @(negedge clk);
    check("ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = w; req_address = a; req_byteSelect = be; req_dataWrite = wd;
    peripheralBus_busy = 1'($urandom);
    e = model(w, a, be, wd, nb, ro, rd);
    e.acc_cyc = cyc;
    sb.push_back(e);
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      check("ready_low", 64'(req_ready), 64'(0));
      if (rsp_valid) begin
        done = 1;
        req_valid = 1'b0;
      end else if (i == reset_at) begin
        #2 rst = 1'b0;
        sb.delete();
        req_valid = 1'b0;
        #1;
        check("rst_drops_strobes", {61'b0, peripheralBus_we, peripheralBus_oe, req_ready}, 64'(0));
        check("rst_clears_regs", {peripheralBus_address, peripheralBus_dataWrite}, 64'(0));
        check("rst_clears_rsp", {31'b0, rsp_valid, rsp_dataRead}, 64'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("ready_after_release", 64'(req_ready), 64'(1));
        done = 1;
      end else begin
        junk_request();
        peripheralBus_busy     = (i < nb);
        requestOutput          = (i < nb) ? 1'($urandom) : ro;
        peripheralBus_dataRead = (i < nb) ? $urandom : rd;
      end
    end
    if (!done) check("rsp_never_seen", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req_valid = 0; req_write = 0; req_address = 0; req_byteSelect = 0; req_dataWrite = 0;
    peripheralBus_busy = 0; peripheralBus_dataRead = 0; requestOutput = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_strobes", {60'b0, peripheralBus_we, peripheralBus_oe, rsp_valid, rsp_error}, 64'(0));
    check("reset_bus", {8'b0, peripheralBus_address, peripheralBus_byteSelect, 28'b0}, 64'(0));
    check("reset_data", {peripheralBus_dataWrite, rsp_dataRead}, 64'(0));
    #2 rst = 1'b1;
    #1 check("ready_at_release", 64'(req_ready), 64'(1));

    run_txn(1'b1, 24'h000104, 4'hF, 32'hDEADBEEF, 0, 1'b0, 32'h0, -1);
    run_txn(1'b0, 24'h000200, 4'hF, 32'h0, 0, 1'b1, 32'h12345678, -1);
    run_txn(1'b0, 24'h000300, 4'h3, 32'h0, 0, 1'b0, 32'hCAFEF00D, -1);
    run_txn(1'b1, 24'h000404, 4'hC, 32'hA5A5_5A5A, 3, 1'b0, 32'h0, -1);
    run_txn(1'b1, 24'h000500, 4'hF, 32'h1111_2222, 8, 1'b1, 32'h0, -1);
    run_txn(1'b0, 24'h000600, 4'hF, 32'h0, 20, 1'b1, 32'h7777_8888, -1);
    run_txn(1'b0, 24'h000700, 4'h1, 32'h0, 7, 1'b1, 32'h0BAD_F00D, -1);
    run_txn(1'b1, 24'h000800, 4'h2, 32'h3333_4444, 7, 1'b0, 32'h0, -1);
    run_txn(1'b1, 24'hABCDEF, 4'hF, 32'h5555_6666, 5, 1'b1, 32'h0, 1);
    run_txn(1'b0, 24'h000900, 4'hF, 32'h0, 1, 1'b1, 32'h9999_AAAA, -1);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom), 24'($urandom), 4'($urandom), $urandom,
              int'($urandom_range(0, 10)), 1'($urandom), $urandom, -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
